// File: rtl/wb_hyperram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of wb_hyperram.
// One classic-cycle transfer per grant, with a per-transfer watchdog.
module wb_hyperram_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Expiry fires in the TIMEOUT_CYCLES-th GRANT cycle (counter starts at 0).
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

    state_t           state;
    logic [1:0]       grant_q;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic req0, req1, own1, in_grant, own_req;
    logic expire, done_ack, expire_err;

    assign req0       = m0_cyc_i & m0_stb_i;
    assign req1       = m1_cyc_i & m1_stb_i;
    assign own1       = grant_q[1];
    assign in_grant   = (state == GRANT);
    assign own_req    = in_grant & (own1 ? req1 : req0);
    assign expire     = WD_ON & (cnt == CNT_LAST);
    assign done_ack   = own_req & s_ack_i;
    assign expire_err = own_req & ~s_ack_i & expire;

    assign s_cyc_o = own_req & ~expire_err;
    assign s_stb_o = own_req & ~expire_err;
    assign s_we_o  = in_grant & (own1 ? m1_we_i : m0_we_i);
    assign s_sel_o = in_grant ? (own1 ? m1_sel_i : m0_sel_i) : 4'h0;
    assign s_adr_o = in_grant ? (own1 ? m1_adr_i : m0_adr_i) : 32'h0;
    assign s_dat_o = in_grant ? (own1 ? m1_dat_i : m0_dat_i) : 32'h0;

    assign m0_ack_o  = done_ack & ~own1;
    assign m1_ack_o  = done_ack & own1;
    assign m0_err_o  = expire_err & ~own1;
    assign m1_err_o  = expire_err & own1;
    assign m0_dat_o  = (in_grant & ~own1) ? s_dat_i : 32'h0;
    assign m1_dat_o  = (in_grant & own1) ? s_dat_i : 32'h0;
    assign timeout_o = expire_err;
    assign grant_o   = grant_q;

    // Arbitration FSM: pick an owner in IDLE, release it after one transfer.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    unique case (1'b1)
                        (req0 & req1): begin
                            state   <= GRANT;
                            grant_q <= last_grant ? 2'b01 : 2'b10;
                        end
                        (req0 & ~req1): begin
                            state   <= GRANT;
                            grant_q <= 2'b01;
                        end
                        (~req0 & req1): begin
                            state   <= GRANT;
                            grant_q <= 2'b10;
                        end
                        default: grant_q <= 2'b00;
                    endcase
                end
                GRANT: begin
                    if (~own_req | done_ack | expire_err) begin
                        state      <= IDLE;
                        grant_q    <= 2'b00;
                        last_grant <= own1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// Directed bench for wb_hyperram_arbiter (watchdog set to 8 cycles).
// Table-driven single transfers plus hand-written corner sequences.
module tb_wb_hyperram_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_adr = 0, m0_dat = 0;
    logic [31:0] m0_rd;
    logic        m0_ack, m0_err;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_adr = 0, m1_dat = 0;
    logic [31:0] m1_rd;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wd;
    logic [31:0] s_rd = 0;
    logic        s_ack = 0;
    logic [1:0]  grant;
    logic        tmo;

    int checks = 0;
    int failures = 0;

    wb_hyperram_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wd),
        .s_dat_i(s_rd), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          delay;
        logic [31:0] rdat;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit m, input logic cs, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
        if (!m) begin
            m0_cyc = cs; m0_stb = cs; m0_we = we;
            m0_sel = sel; m0_adr = adr; m0_dat = dat;
        end else begin
            m1_cyc = cs; m1_stb = cs; m1_we = we;
            m1_sel = sel; m1_adr = adr; m1_dat = dat;
        end
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        s_ack = 0;
        s_rd  = 32'h0;
    endtask

    initial begin
        vec_t v;
        int acks;
        logic [1:0] eg;

        vecs[0] = '{0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 3,
                    32'hCAFE_F00D, 2'b01};
        vecs[1] = '{1, 1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678, 2,
                    32'h0, 2'b10};
        vecs[2] = '{0, 1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 0,
                    32'h0, 2'b01};
        vecs[3] = '{1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 7,
                    32'hDEAD_BEEF, 2'b10};
        vecs[4] = '{0, 1'b0, 4'b0110, 32'h0000_0040, 32'h0, 6,
                    32'h0BAD_F00D, 2'b01};

        // Reset state
        idle_all();
        rstn = 0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        rstn = 1;
        tick();

        // Table of single-master transfers
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            set_m(v.m, 1, v.we, v.sel, v.adr, v.wdat);
            set_m(!v.m, 0, ~v.we, ~v.sel, ~v.adr, ~v.wdat);
            #1;
            chk($sformatf("v%0d_pre_grant", i), 32'(grant), 32'h0);
            chk($sformatf("v%0d_pre_stb", i), 32'(s_stb), 32'h0);
            tick();
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(v.exp_grant));
            for (int j = 0; j <= v.delay; j++) begin
                if (j == v.delay) begin
                    s_ack = 1;
                    s_rd  = v.rdat;
                end
                #1;
                chk($sformatf("v%0d_stb_%0d", i, j), 32'(s_stb), 32'h1);
                chk($sformatf("v%0d_we_%0d", i, j), 32'(s_we), 32'(v.we));
                chk($sformatf("v%0d_sel_%0d", i, j), 32'(s_sel), 32'(v.sel));
                chk($sformatf("v%0d_adr_%0d", i, j), s_adr, v.adr);
                chk($sformatf("v%0d_wdat_%0d", i, j), s_wd, v.wdat);
                chk($sformatf("v%0d_ack_%0d", i, j),
                    32'(v.m ? m1_ack : m0_ack), 32'(j == v.delay));
                if (j == v.delay) begin
                    chk($sformatf("v%0d_rdat", i),
                        v.m ? m1_rd : m0_rd, v.rdat);
                    chk($sformatf("v%0d_oth_ack", i),
                        32'(v.m ? m0_ack : m1_ack), 32'h0);
                    chk($sformatf("v%0d_oth_rdat", i),
                        v.m ? m0_rd : m1_rd, 32'h0);
                    chk($sformatf("v%0d_err", i),
                        {30'h0, m1_err, m0_err}, 32'h0);
                    chk($sformatf("v%0d_tmo", i), 32'(tmo), 32'h0);
                end else begin
                    tick();
                end
            end
            tick();
            idle_all();
            #1;
            chk($sformatf("v%0d_post_grant", i), 32'(grant), 32'h0);
            chk($sformatf("v%0d_post_acks", i),
                {30'h0, m1_ack, m0_ack}, 32'h0);
        end

        // Contention from reset: strict alternation, m0 first
        rstn = 0;
        tick();
        rstn = 1;
        set_m(0, 1, 0, 4'hF, 32'h0000_1000, 32'h0);
        set_m(1, 1, 0, 4'hF, 32'h0000_2000, 32'h0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr%0d_grant", i), 32'(grant), 32'(eg));
            chk($sformatf("rr%0d_adr", i), s_adr,
                eg[0] ? 32'h0000_1000 : 32'h0000_2000);
            s_ack = 1;
            s_rd  = 32'(i);
            #1;
            chk($sformatf("rr%0d_acks", i),
                {30'h0, m1_ack, m0_ack}, 32'(eg));
            acks += int'(m0_ack) + int'(m1_ack);
            tick();
            s_ack = 0;
            #1;
            chk($sformatf("rr%0d_idle", i), 32'(grant), 32'h0);
        end
        chk("rr_total_acks", 32'(acks), 32'd8);
        idle_all();
        tick();

        // Watchdog: slave never acks m0
        set_m(0, 1, 0, 4'hF, 32'h0000_0300, 32'h0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("wd%0d_err", k), 32'(m0_err), 32'(k == 8));
            chk($sformatf("wd%0d_tmo", k), 32'(tmo), 32'(k == 8));
            chk($sformatf("wd%0d_cyc", k), 32'(s_cyc), 32'(k != 8));
            chk($sformatf("wd%0d_ack", k), 32'(m0_ack), 32'h0);
            if (k < 8) tick();
        end
        tick();
        idle_all();
        #1;
        chk("wd_after_err", {29'h0, tmo, m1_err, m0_err}, 32'h0);
        chk("wd_after_grant", 32'(grant), 32'h0);
        tick(); tick();
        s_ack = 1;
        s_rd  = 32'h5555_AAAA;
        #1;
        chk("wd_late_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("wd_late_rdat", m0_rd | m1_rd, 32'h0);
        tick();
        s_ack = 0;

        // Abort: m1 drops cyc in its second GRANT cycle, m0 waits
        set_m(1, 1, 0, 4'hF, 32'h0000_0400, 32'h0);
        tick();
        chk("ab_grant_m1", 32'(grant), 32'h2);
        set_m(0, 1, 1, 4'h3, 32'h0000_0500, 32'h7777_0000);
        tick();
        m1_cyc = 0;
        #1;
        chk("ab_scyc", 32'(s_cyc), 32'h0);
        chk("ab_sstb", 32'(s_stb), 32'h0);
        chk("ab_ackerr", {28'h0, m1_err, m0_err, m1_ack, m0_ack}, 32'h0);
        tick();
        chk("ab_idle", 32'(grant), 32'h0);
        tick();
        chk("ab_grant_m0", 32'(grant), 32'h1);
        chk("ab_m0_adr", s_adr, 32'h0000_0500);
        s_ack = 1;
        #1;
        chk("ab_m0_ack", 32'(m0_ack), 32'h1);
        tick();
        idle_all();
        tick();

        // Async reset during GRANT, then tie goes to m0
        set_m(1, 1, 0, 4'hF, 32'h0000_0600, 32'h0);
        tick();
        chk("ar_grant_m1", 32'(grant), 32'h2);
        set_m(0, 1, 0, 4'hF, 32'h0000_0700, 32'h0);
        s_ack = 1;
        #1;
        chk("ar_pre_ack", 32'(m1_ack), 32'h1);
        #1;
        rstn = 0;
        #1;
        chk("ar_scyc", 32'(s_cyc), 32'h0);
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        s_ack = 0;
        @(posedge clk);
        #1;
        chk("ar_hold_grant", 32'(grant), 32'h0);
        rstn = 1;
        tick();
        chk("ar_first_grant", 32'(grant), 32'h1);
        idle_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
